// File: rtl/step_seq_ctrl.sv
// Single-axis motion segment scheduler: queues segments, applies direction with a setup
// delay, sequences one step-pulse generator and accumulates absolute step position.
module step_seq_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DIR_SETUP   = 50,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic                   seg_dir,
    input  logic [30:0]            seg_steps,
    input  logic [31:0]            seg_period,
    input  logic                   abort,
    input  logic                   clear_fault,
    output logic                   gen_run,
    output logic [30:0]            gen_count,
    output logic [31:0]            gen_reduction,
    input  logic                   gen_finish,
    output logic                   dir_out,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [31:0]            position,
    output logic                   fault
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW   = $clog2(DEPTH) + 1;
    localparam int unsigned CMAX = (DIR_SETUP > ACK_TIMEOUT) ? DIR_SETUP : ACK_TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StDirWait = 3'd2;
    localparam logic [2:0] StStart   = 3'd3;
    localparam logic [2:0] StRun     = 3'd4;
    localparam logic [2:0] StGap     = 3'd5;
    localparam logic [2:0] StFault   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [LW-1:0] level_d;
    logic          seg_dir_q, seg_dir_d;
    logic          push, pop;
    logic [63:0]   head;
    logic [63:0]   mem [DEPTH];

    logic          gen_run_d, dir_d, fault_d;
    logic [30:0]   gen_count_d;
    logic [31:0]   gen_reduction_d, position_d;

    assign seg_ready = (fifo_level != FULL_LEVEL);
    assign push      = seg_valid && seg_ready && !abort;
    assign head      = mem[rd_ptr_q];
    assign busy      = (state_q != StIdle) || (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {seg_dir, seg_steps, seg_period};
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        seg_dir_d       = seg_dir_q;
        gen_count_d     = gen_count;
        gen_reduction_d = gen_reduction;
        dir_d           = dir_out;
        position_d      = position;
        fault_d         = fault;
        pop             = 1'b0;

        if (clear_fault) begin
            fault_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // Head is popped here; its fields are held for the LOAD decision.
                if (fifo_level != '0 && !fault) begin
                    pop                                       = 1'b1;
                    {seg_dir_d, gen_count_d, gen_reduction_d} = head;
                    state_d                                   = StLoad;
                end
            end
            StLoad: begin
                if (gen_count == '0) begin
                    state_d = StIdle;
                end else if (seg_dir_q != dir_out) begin
                    dir_d   = seg_dir_q;
                    cnt_d   = CW'(DIR_SETUP - 1);
                    state_d = StDirWait;
                end else begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StDirWait: begin
                if (cnt_q == '0) begin
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StStart: begin
                if (!gen_finish) begin
                    state_d = StRun;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRun: begin
                if (gen_finish) begin
                    position_d = seg_dir_q ? position + {1'b0, gen_count}
                                           : position - {1'b0, gen_count};
                    state_d    = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            StFault: begin
                if (clear_fault) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over everything except the sticky fault flag.
        if (abort) begin
            state_d         = StIdle;
            cnt_d           = '0;
            pop             = 1'b0;
            seg_dir_d       = seg_dir_q;
            gen_count_d     = gen_count;
            gen_reduction_d = gen_reduction;
            dir_d           = dir_out;
            position_d      = position;
            fault_d         = fault;
        end

        gen_run_d = (state_d == StStart) || (state_d == StRun);
    end

    always_comb begin
        level_d = fifo_level;
        if (abort) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = fifo_level + LW'(1);
        end else if (pop && !push) begin
            level_d = fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_level    <= '0;
            seg_dir_q     <= 1'b0;
            gen_run       <= 1'b0;
            gen_count     <= '0;
            gen_reduction <= '0;
            dir_out       <= 1'b0;
            position      <= '0;
            fault         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fifo_level    <= level_d;
            seg_dir_q     <= seg_dir_d;
            gen_run       <= gen_run_d;
            gen_count     <= gen_count_d;
            gen_reduction <= gen_reduction_d;
            dir_out       <= dir_d;
            position      <= position_d;
            fault         <= fault_d;
            if (abort) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
        end
    end

endmodule
